dac_spi_responder: RTL
======================

DAC_SPI_RESPONDER -- requirements
Module: dac_spi_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; port list (name  direction  width  meaning):
REQ-002 CLK_50M  in  1  system clock, 50 MHz, all state on rising edge.
REQ-003 RST  in  1  synchronous active-high reset.
REQ-004 SPI_SCK  in  1  serial clock from the DAC initiator, asynchronous to CLK_50M.
REQ-005 SPI_MOSI  in  1  serial data, MSB first, valid at SPI_SCK rising edge.
REQ-006 DAC_CS  in  1  active-low frame select.
REQ-007 DAC_CLR  in  1  active-low clear of all DAC registers.
REQ-008 Va, Vb, Vc, Vd  out  12 each  current DAC output register of channels A-D.
REQ-009 frame_valid  out  1  one-cycle pulse when a well-formed frame is decoded.
REQ-010 frame_error  out  1  one-cycle pulse when a frame is rejected.
REQ-011 last_cmd, last_addr  out  4 each  command and address of the last valid frame.

Function
REQ-012 SPI_SCK, SPI_MOSI and DAC_CS SHALL each pass through a 2-flop synchronizer; all edge detection SHALL use the synchronized signals.
REQ-013 The input SHALL require SPI_SCK high and low phases of at least 3 CLK_50M cycles; faster clocks are out of scope.
REQ-014 FSM states: IDLE, SHIFT, DECODE. IDLE -> SHIFT on a synchronized DAC_CS falling edge. SHIFT -> DECODE on a synchronized DAC_CS rising edge. DECODE -> IDLE after exactly one cycle.
REQ-015 On entry to SHIFT, the 32-bit shift register and the 6-bit bit counter SHALL clear to 0.
REQ-016 In SHIFT, each synchronized SPI_SCK rising edge SHALL shift SPI_MOSI into bit 0 and increment the counter; the counter saturates at 33.
REQ-017 An SPI_SCK rising edge detected in the same cycle as the DAC_CS rising edge SHALL be ignored.
REQ-018 Frame layout, bits 31..0: [31:24] don't-care, [23:20] cmd, [19:16] addr, [15:4] data, [3:0] don't-care.
REQ-019 In DECODE, a bit count other than 32 SHALL pulse frame_error and change no register.
REQ-020 Commands SHALL behave as follows:
- 0000: write input register n.
- 0001: copy input register n to DAC register n.
- 0010: write input register n, then copy all four input registers to the DAC registers.
- 0011: write input register n and update DAC register n.
- 0100 and 1111: no register change.
- Any other cmd: pulse frame_error.
REQ-021 Address decode: 0000..0011 select A..D; 1111 selects all four channels; any other address gives a valid frame with no register change.
REQ-022 For command 0010, the copy SHALL use the newly written value for channel n.
REQ-023 For every valid frame, frame_valid SHALL pulse, and last_cmd and last_addr SHALL load in the same cycle.
REQ-024 Latency: register updates and pulses SHALL be visible on the 4th CLK_50M rising edge after the first edge that samples DAC_CS high (2 sync, 1 edge detect, 1 DECODE).
REQ-025 While synchronized DAC_CLR is low, all input and DAC registers SHALL be held at 0, overriding any DECODE update in the same cycle; the FSM, pulses and last_cmd/last_addr are unaffected.
REQ-026 frame_valid and frame_error SHALL never be high in the same cycle.

Reset
REQ-027 While RST is high, the FSM SHALL go to IDLE, and all outputs, internal registers and synchronizers SHALL clear to 0.
REQ-028 RST SHALL override every other input in the same cycle.
REQ-029 After RST is released while DAC_CS is low, the block SHALL stay in IDLE until a new DAC_CS falling edge; the partial frame SHALL be discarded without a frame_error pulse.

Verification
REQ-030 Frame 0x00_3_1_ABC_0 (write and update B) -> Vb = 0xABC, last_cmd = 3, last_addr = 1, one frame_valid pulse at the latency of REQ-024; Va/Vc/Vd stay 0.
REQ-031 Frame cmd 0 addr F data 0x123, then frame cmd 1 addr 2 -> after the first frame all DAC registers stay 0; after the second, Vc = 0x123 and the others stay 0.
REQ-032 31-bit frame, then a 33-bit frame -> each gives one frame_error pulse and no register change.
REQ-033 DAC_CLR held low across a cmd 3 addr 0 frame -> Va stays 0 and frame_valid still pulses; after DAC_CLR is released, Va stays 0 until the next write.
REQ-034 RST asserted after bit 12 of a frame with DAC_CS still low, released, CS then rises, then a fresh valid frame -> no pulse for the aborted frame; the fresh frame decodes correctly.
REQ-035 SPI_SCK rising in the same CLK_50M cycle as DAC_CS rising after 32 bits -> the extra edge is ignored and the frame is valid.

Source files
------------

// File: rtl/dac_spi_responder_if.sv
// SPI pins from a DAC initiator together with the decoded DAC register view.
// Frame protocol: DAC_CS low opens a frame, MOSI is sampled on SCK rising edges (MSB first), DAC_CS high closes it.
interface dac_spi_responder_if;
  logic        SPI_SCK;
  logic        SPI_MOSI;
  logic        DAC_CS;
  logic        DAC_CLR;
  logic [11:0] Va;
  logic [11:0] Vb;
  logic [11:0] Vc;
  logic [11:0] Vd;
  logic        frame_valid;
  logic        frame_error;
  logic [3:0]  last_cmd;
  logic [3:0]  last_addr;

  modport master (
    output SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR,
    input  Va, Vb, Vc, Vd, frame_valid, frame_error, last_cmd, last_addr
  );

  modport slave (
    input  SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR,
    output Va, Vb, Vc, Vd, frame_valid, frame_error, last_cmd, last_addr
  );
endinterface

// File: rtl/dac_spi_responder.sv
// Four-channel DAC register model behind an SPI responder: shifts a 32-bit frame,
// decodes cmd/addr/data on DAC_CS rising and updates input/DAC registers.
module dac_spi_responder (
  input  logic               CLK_50M,
  input  logic               RST,
  dac_spi_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DECODE = 2'd2} state_t;

  state_t      state_q;
  logic [2:0]  sck_q;
  logic [2:0]  cs_q;
  logic [1:0]  mosi_q;
  logic [1:0]  clr_q;
  logic [31:0] shift_q;
  logic [5:0]  cnt_q;
  logic [11:0] in_q  [4];
  logic [11:0] dac_q [4];
  logic [11:0] in_d  [4];
  logic [11:0] dac_d [4];
  logic        valid_q, error_q, valid_d, error_d;
  logic [3:0]  last_cmd_q, last_addr_q;

  logic        sck_rise, cs_rise, cs_fall, addr_ok, sel;
  logic [3:0]  cmd, addr;
  logic [11:0] data;
  logic        unused_bits;

  // Index [1] is the synchronizer output, [2] its previous value for edge detection.
  assign sck_rise    = sck_q[1] & ~sck_q[2];
  assign cs_rise     = cs_q[1] & ~cs_q[2];
  assign cs_fall     = ~cs_q[1] & cs_q[2];
  assign cmd         = shift_q[23:20];
  assign addr        = shift_q[19:16];
  assign data        = shift_q[15:4];
  assign addr_ok     = (addr < 4'd4) || (addr == 4'hF);
  assign unused_bits = ^{shift_q[31:24], shift_q[3:0]};

  always_comb begin
    valid_d = 1'b0;
    error_d = 1'b0;
    sel     = 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      in_d[ch]  = in_q[ch];
      dac_d[ch] = dac_q[ch];
    end
    if (state_q == DECODE) begin
      if (cnt_q != 6'd32) begin
        error_d = 1'b1;
      end else begin
        case (cmd)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF: valid_d = 1'b1;
          default:                            error_d = 1'b1;
        endcase
        for (int ch = 0; ch < 4; ch++) begin
          sel = (addr == 4'hF) || (addr == 4'(ch));
          if (sel) begin
            case (cmd)
              4'h0, 4'h2: in_d[ch] = data;
              4'h1:       dac_d[ch] = in_q[ch];
              4'h3: begin
                in_d[ch]  = data;
                dac_d[ch] = data;
              end
              default: ;
            endcase
          end
        end
        // Broadcast update sees the value written by this same frame.
        if (cmd == 4'h2 && addr_ok) begin
          for (int ch = 0; ch < 4; ch++) dac_d[ch] = in_d[ch];
        end
      end
    end
    if (!clr_q[1]) begin
      for (int ch = 0; ch < 4; ch++) begin
        in_d[ch]  = '0;
        dac_d[ch] = '0;
      end
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      state_q     <= IDLE;
      sck_q       <= '0;
      cs_q        <= '0;
      mosi_q      <= '0;
      clr_q       <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      last_cmd_q  <= '0;
      last_addr_q <= '0;
      for (int ch = 0; ch < 4; ch++) begin
        in_q[ch]  <= '0;
        dac_q[ch] <= '0;
      end
    end else begin
      sck_q   <= {sck_q[1:0], bus.SPI_SCK};
      cs_q    <= {cs_q[1:0], bus.DAC_CS};
      mosi_q  <= {mosi_q[0], bus.SPI_MOSI};
      clr_q   <= {clr_q[0], bus.DAC_CLR};
      valid_q <= valid_d;
      error_q <= error_d;
      for (int ch = 0; ch < 4; ch++) begin
        in_q[ch]  <= in_d[ch];
        dac_q[ch] <= dac_d[ch];
      end
      if (valid_d) begin
        last_cmd_q  <= cmd;
        last_addr_q <= addr;
      end
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q <= SHIFT;
            shift_q <= '0;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          // A clock edge coinciding with frame close is not part of the frame.
          if (cs_rise) begin
            state_q <= DECODE;
          end else if (sck_rise) begin
            shift_q <= {shift_q[30:0], mosi_q[1]};
            if (cnt_q != 6'd33) cnt_q <= cnt_q + 6'd1;
          end
        end
        DECODE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Va          = dac_q[0];
  assign bus.Vb          = dac_q[1];
  assign bus.Vc          = dac_q[2];
  assign bus.Vd          = dac_q[3];
  assign bus.frame_valid = valid_q;
  assign bus.frame_error = error_q;
  assign bus.last_cmd    = last_cmd_q;
  assign bus.last_addr   = last_addr_q;
endmodule
